intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have the parameter SYNC_STAGES, default 2, giving the number of synchronizer flops per interrupt input; legal range 2..3.
REQ-002 SHALL have the port irq_clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have the port init_n: input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have the ports EXTI1_n, EXTI2_n, EXTI4_n, EXTI8_n: input, 1 bit each, asynchronous external interrupt lines, active-low, falling-edge triggered.
REQ-005 SHALL have the port sigma_bus: input, 4 bits, data for mask load; bit0..bit3 map to EXTI1, EXTI2, EXTI4, EXTI8.
REQ-006 SHALL have the port mask_wr: input, 1 bit, one-cycle strobe that loads mask from sigma_bus.
REQ-007 SHALL have the port int_ack: input, 1 bit, one-cycle strobe from the microcode sequencer accepting the request.
REQ-008 SHALL have the port eoi: input, 1 bit, one-cycle end-of-interrupt strobe.
REQ-009 SHALL have the port int_req: output, 1 bit, interrupt request to the sequencer.
REQ-010 SHALL have the port int_vec: output, 4 bits, one-hot source of the request or service in progress (weights 1, 2, 4, 8).
REQ-011 SHALL have the ports pending and mask: output, 4 bits each, status.
REQ-012 SHALL have the port in_service: output, 1 bit, high while a handler runs.

Function
REQ-013 SHALL pass each EXTIx_n through SYNC_STAGES flops plus one history flop; a synchronized 1->0 transition sets pending[x] for exactly that edge.
REQ-014 SHALL set pending on the (SYNC_STAGES+1)th rising edge after the first edge that samples the input low; int_req SHALL follow one edge later.
REQ-015 SHALL ignore level: a held-low line produces one event; a second event requires return high for at least 1 synchronized cycle.
REQ-016 SHALL treat eligible sources as pending & ~mask; priority is fixed: EXTI1 highest, EXTI8 lowest.
REQ-017 SHALL implement the FSM IDLE -> REQ -> SERVICE -> IDLE.
REQ-018 In IDLE, any eligible source SHALL cause a transition to REQ, latch the highest-priority source into int_vec, and assert int_req.
REQ-019 In REQ, int_ack SHALL clear pending[int_vec], deassert int_req, and enter SERVICE; the request SHALL stay asserted until acknowledged, even if mask changes.
REQ-020 In SERVICE, in_service=1 and int_vec SHALL hold; eoi SHALL return to IDLE and clear int_vec.
REQ-021 SHALL ignore int_ack outside REQ and eoi outside SERVICE, with no state change.
REQ-022 A new edge on a source in the same cycle its pending bit is cleared by int_ack SHALL leave it pending (set wins).
REQ-023 mask_wr SHALL take effect for the next cycle's eligibility; masked sources SHALL still latch pending.
REQ-024 eoi and a new eligible source in the same cycle SHALL go to IDLE; the request SHALL issue on the following edge.

Reset
REQ-025 While init_n=0, all flops SHALL clear asynchronously: state=IDLE, pending=0, mask=4'b1111 (all masked), int_vec=0, int_req=0, in_service=0; synchronizer flops SHALL preset to 1 (line idle high).
REQ-026 Reset mid-REQ or mid-SERVICE SHALL abandon the interrupt with no residual pending bit.
REQ-027 Release of init_n SHALL be synchronous-safe: a line already low at release SHALL NOT produce an event.

Configuration
REQ-028 With INTR_NESTING_EN defined, in SERVICE an eligible source of strictly higher priority than int_vec SHALL assert int_req; int_ack SHALL push the current int_vec into a one-entry save register and serve the new source; eoi SHALL pop and resume SERVICE with the saved vector; with the save register full, no further preemption SHALL occur.
REQ-029 Without INTR_NESTING_EN, int_req SHALL never assert in SERVICE and no save register SHALL exist.

Verification
REQ-030 Reset, load mask=0000, pulse EXTI4_n low for 5 cycles -> pending=0100 after 3 edges, int_req=1 and int_vec=0100 one edge later.
REQ-031 EXTI8_n and EXTI2_n fall together -> int_vec=0010; after ack+eoi, int_vec=1000 is requested.
REQ-032 Mask=0001, EXTI1_n falls -> pending=0001, int_req=0; load mask=0000 -> int_req=1 the next cycle.
REQ-033 EXTI2_n re-falls in the int_ack cycle for EXTI2 -> pending[1]=1 remains; after eoi, a second request with vec=0010 issues.
REQ-034 Assert init_n=0 during SERVICE -> all outputs 0, mask=1111 immediately, without waiting for a clock.
REQ-035 (INTR_NESTING_EN) Serving EXTI8, EXTI1 falls -> int_req=1, vec=0001; on eoi, vec=1000 with in_service=1; a second eoi -> IDLE.

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl: four-line edge-triggered interrupt controller with fixed priority
// (EXTI1 highest, EXTI8 lowest), a per-source mask and an IDLE/REQ/SERVICE handshake.
// Optional single-level preemption is compiled in with `define INTR_NESTING_EN.
module intr_ctrl #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic       irq_clk,
  input  logic       init_n,
  input  logic       EXTI1_n,
  input  logic       EXTI2_n,
  input  logic       EXTI4_n,
  input  logic       EXTI8_n,
  input  logic [3:0] sigma_bus,
  input  logic       mask_wr,
  input  logic       int_ack,
  input  logic       eoi,
  output logic       int_req,
  output logic [3:0] int_vec,
  output logic [3:0] pending,
  output logic [3:0] mask,
  output logic       in_service
);

  localparam int unsigned N_SRC = 4;
  // Edge detection stays disarmed until the synchronizer and history flop have
  // been flushed with real samples, so a line already low at reset release is ignored.
  localparam int unsigned ARM_W = SYNC_STAGES + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t                              state;
  logic [N_SRC-1:0]                    line_raw;
  logic [SYNC_STAGES-1:0][N_SRC-1:0]   sync_q;
  logic [N_SRC-1:0]                    hist_q;
  logic [ARM_W-1:0]                    arm_q;
  logic [N_SRC-1:0]                    fall_vec;
  logic [N_SRC-1:0]                    eligible;
  logic [N_SRC-1:0]                    top_vec;
  logic [N_SRC-1:0]                    clr_vec;
`ifdef INTR_NESTING_EN
  logic [N_SRC-1:0]                    save_vec;
  logic                                save_valid;
  logic                                nest_hit;
`endif

  assign line_raw = {EXTI8_n, EXTI4_n, EXTI2_n, EXTI1_n};

  // Synchronizer chain, history flop and post-reset arming shift register.
  always_ff @(posedge irq_clk or negedge init_n) begin
    if (!init_n) begin
      sync_q <= '1;
      hist_q <= '1;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_raw};
      hist_q <= sync_q[SYNC_STAGES-1];
      arm_q  <= {arm_q[ARM_W-2:0], 1'b1};
    end
  end

  // Falling-edge events, eligibility and highest-priority pick (lowest set bit).
  always_comb begin
    fall_vec = '0;
    if (&arm_q) fall_vec = hist_q & ~sync_q[SYNC_STAGES-1];
    eligible = pending & ~mask;
    top_vec  = eligible & (~eligible + N_SRC'(1));
  end

  // Pending bits cleared by an accepted request; a same-cycle new edge still wins.
  always_comb begin
    clr_vec = '0;
    if (state == S_REQ && int_ack) clr_vec = int_vec;
`ifdef INTR_NESTING_EN
    if (state == S_SERVICE && int_req && int_ack) clr_vec = int_vec;
    nest_hit = (top_vec != '0) && (top_vec < int_vec) && !save_valid && !int_req;
`endif
  end

  // Request/service state machine with registered status outputs.
  always_ff @(posedge irq_clk or negedge init_n) begin
    if (!init_n) begin
      state      <= S_IDLE;
      pending    <= '0;
      mask       <= '1;
      int_vec    <= '0;
      int_req    <= 1'b0;
      in_service <= 1'b0;
`ifdef INTR_NESTING_EN
      save_vec   <= '0;
      save_valid <= 1'b0;
`endif
    end else begin
      pending <= (pending & ~clr_vec) | fall_vec;
      if (mask_wr) mask <= sigma_bus;
      case (state)
        S_IDLE: begin
          if (eligible != '0) begin
            state   <= S_REQ;
            int_vec <= top_vec;
            int_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            state      <= S_SERVICE;
            int_req    <= 1'b0;
            in_service <= 1'b1;
          end
        end
        S_SERVICE: begin
`ifdef INTR_NESTING_EN
          if (int_req && int_ack) begin
            // Preemption accepted; if the running handler also ended, nothing to save.
            int_req    <= 1'b0;
            save_valid <= !eoi;
          end else if (eoi) begin
            if (int_req) begin
              // Handler ended before the preempting request was taken: plain request.
              state      <= S_REQ;
              in_service <= 1'b0;
            end else if (save_valid) begin
              int_vec    <= save_vec;
              save_valid <= 1'b0;
            end else begin
              state      <= S_IDLE;
              int_vec    <= '0;
              in_service <= 1'b0;
            end
          end else if (nest_hit) begin
            save_vec <= int_vec;
            int_vec  <= top_vec;
            int_req  <= 1'b1;
          end
`else
          if (eoi) begin
            state      <= S_IDLE;
            int_vec    <= '0;
            in_service <= 1'b0;
          end
`endif
        end
        default: begin
          state      <= S_IDLE;
          int_vec    <= '0;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scoreboard bench for intr_ctrl. Expected request vectors
// are queued as stimulus is issued; a monitor pops one on every rising int_req.
module tb_intr_ctrl;

  logic       irq_clk = 1'b0;
  logic       init_n;
  logic [3:0] lines;
  logic [3:0] sigma_bus;
  logic       mask_wr, int_ack, eoi;
  logic       int_req, in_service;
  logic [3:0] int_vec, pending, mask;

  int total = 0;
  int bad   = 0;
  logic [3:0] sb[$];

  intr_ctrl #(.SYNC_STAGES(2)) dut (
    .irq_clk    (irq_clk),
    .init_n     (init_n),
    .EXTI1_n    (lines[0]),
    .EXTI2_n    (lines[1]),
    .EXTI4_n    (lines[2]),
    .EXTI8_n    (lines[3]),
    .sigma_bus  (sigma_bus),
    .mask_wr    (mask_wr),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  always #5 irq_clk = ~irq_clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge irq_clk);
      #1;
    end
  endtask

  task automatic set_mask(input logic [3:0] v);
    sigma_bus = v;
    mask_wr   = 1'b1;
    tick(1);
    mask_wr   = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  // Bounded wait for int_req; an expired bound counts as a failure.
  task automatic wait_req(input string name);
    int n = 0;
    while (!int_req && n < 12) begin
      tick(1);
      n++;
    end
    if (!int_req) chk(name, 4'(int_req), 4'd1);
  endtask

  // Scoreboard monitor: every new request must match the oldest queued vector.
  initial begin
    logic prev = 1'b0;
    logic [3:0] exp;
    forever begin
      @(negedge irq_clk);
      if (int_req && !prev) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_req actual_vec=%b expected=none t=%0t", int_vec, $time);
        end else begin
          exp = sb.pop_front();
          if (int_vec !== exp) begin
            bad++;
            $display("FAIL sb_vec actual=%b expected=%b t=%0t", int_vec, exp, $time);
          end
        end
      end
      prev = int_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    init_n    = 1'b0;
    lines     = 4'b1111;
    sigma_bus = 4'b0000;
    mask_wr   = 1'b0;
    int_ack   = 1'b0;
    eoi       = 1'b0;
    #12;
    chk("rst_pending", pending, 4'b0000);
    chk("rst_mask", mask, 4'b1111);
    chk("rst_vec", int_vec, 4'b0000);
    chk("rst_req", 4'(int_req), 4'd0);
    chk("rst_insvc", 4'(in_service), 4'd0);
    #11 init_n = 1'b1;
    tick(5);

    // Single EXTI4 event: pending on 3rd edge, request one edge later.
    set_mask(4'b0000);
    chk("mask_load", mask, 4'b0000);
    sb.push_back(4'b0100);
    lines[2] = 1'b0;
    tick(2);
    chk("e4_pend_early", pending, 4'b0000);
    tick(1);
    chk("e4_pend", pending, 4'b0100);
    chk("e4_req_early", 4'(int_req), 4'd0);
    tick(1);
    chk("e4_req", 4'(int_req), 4'd1);
    chk("e4_vec", int_vec, 4'b0100);
    tick(1);
    lines[2] = 1'b1;
    pulse_ack();
    chk("e4_ack_pend", pending, 4'b0000);
    chk("e4_ack_req", 4'(int_req), 4'd0);
    chk("e4_ack_insvc", 4'(in_service), 4'd1);
    chk("e4_svc_vec", int_vec, 4'b0100);
    pulse_eoi();
    chk("e4_eoi_insvc", 4'(in_service), 4'd0);
    chk("e4_eoi_vec", int_vec, 4'b0000);
    tick(4);
    int_ack = 1'b1;
    eoi     = 1'b1;
    tick(1);
    int_ack = 1'b0;
    eoi     = 1'b0;
    chk("idle_strobe_req", 4'(int_req), 4'd0);
    chk("idle_strobe_insvc", 4'(in_service), 4'd0);

    // EXTI8 and EXTI2 together: EXTI2 first, EXTI8 requested right after eoi.
    sb.push_back(4'b0010);
    sb.push_back(4'b1000);
    lines[1] = 1'b0;
    lines[3] = 1'b0;
    tick(3);
    chk("dual_pend", pending, 4'b1010);
    wait_req("dual_req1_timeout");
    pulse_ack();
    chk("dual_ack_pend", pending, 4'b1000);
    pulse_eoi();
    wait_req("dual_req2_timeout");
    chk("dual_vec2", int_vec, 4'b1000);
    pulse_ack();
    pulse_eoi();
    lines[1] = 1'b1;
    lines[3] = 1'b1;
    chk("dual_pend_done", pending, 4'b0000);
    tick(4);

    // Masked EXTI1 latches pending but only requests once unmasked.
    set_mask(4'b0001);
    lines[0] = 1'b0;
    tick(5);
    chk("msk_pend", pending, 4'b0001);
    chk("msk_req", 4'(int_req), 4'd0);
    sb.push_back(4'b0001);
    set_mask(4'b0000);
    chk("msk_req_load", 4'(int_req), 4'd0);
    tick(1);
    chk("msk_req_next", 4'(int_req), 4'd1);
    pulse_eoi();
    chk("req_eoi_ign_req", 4'(int_req), 4'd1);
    chk("req_eoi_ign_insvc", 4'(in_service), 4'd0);
    set_mask(4'b1111);
    chk("req_hold_mask", 4'(int_req), 4'd1);
    pulse_ack();
    pulse_eoi();
    set_mask(4'b0000);
    lines[0] = 1'b1;
    tick(4);

    // EXTI2 re-falls so its event lands on the same edge as the ack: set wins.
    sb.push_back(4'b0010);
    lines[1] = 1'b0;
    wait_req("refall_req1_timeout");
    lines[1] = 1'b1;
    tick(2);
    lines[1] = 1'b0;
    tick(2);
    sb.push_back(4'b0010);
    pulse_ack();
    chk("refall_pend", pending, 4'b0010);
    chk("refall_insvc", 4'(in_service), 4'd1);
    pulse_eoi();
    wait_req("refall_req2_timeout");
    pulse_ack();
    pulse_eoi();
    lines[1] = 1'b1;
    chk("refall_pend_done", pending, 4'b0000);
    tick(4);

    // Asynchronous reset during SERVICE with a residual pending bit.
    sb.push_back(4'b0001);
    lines[0] = 1'b0;
    lines[3] = 1'b0;
    wait_req("rst_svc_req_timeout");
    pulse_ack();
    chk("rst_svc_insvc", 4'(in_service), 4'd1);
    #2 init_n = 1'b0;
    #1;
    chk("arst_req", 4'(int_req), 4'd0);
    chk("arst_vec", int_vec, 4'b0000);
    chk("arst_pend", pending, 4'b0000);
    chk("arst_insvc", 4'(in_service), 4'd0);
    chk("arst_mask", mask, 4'b1111);
    tick(2);
    #2 init_n = 1'b1;
    tick(1);
    set_mask(4'b0000);
    tick(6);
    chk("rel_low_pend", pending, 4'b0000);
    chk("rel_low_req", 4'(int_req), 4'd0);
    lines[0] = 1'b1;
    lines[3] = 1'b1;
    tick(5);

    // Higher-priority EXTI1 arrives while EXTI8 is in service.
    sb.push_back(4'b1000);
    lines[3] = 1'b0;
    wait_req("svc8_req_timeout");
    pulse_ack();
`ifdef INTR_NESTING_EN
    sb.push_back(4'b0001);
    lines[0] = 1'b0;
    wait_req("nest_req_timeout");
    chk("nest_vec", int_vec, 4'b0001);
    pulse_ack();
    chk("nest_ack_insvc", 4'(in_service), 4'd1);
    chk("nest_ack_pend", pending, 4'b0000);
    pulse_eoi();
    chk("nest_pop_vec", int_vec, 4'b1000);
    chk("nest_pop_insvc", 4'(in_service), 4'd1);
    pulse_eoi();
    chk("nest_done_vec", int_vec, 4'b0000);
    chk("nest_done_insvc", 4'(in_service), 4'd0);
`else
    lines[0] = 1'b0;
    tick(5);
    chk("nonest_req", 4'(int_req), 4'd0);
    chk("nonest_vec", int_vec, 4'b1000);
    chk("nonest_pend", pending, 4'b0001);
    sb.push_back(4'b0001);
    pulse_eoi();
    wait_req("nonest_req2_timeout");
    pulse_ack();
    pulse_eoi();
`endif
    lines[0] = 1'b1;
    lines[3] = 1'b1;
    tick(5);
    chk("sb_empty", 4'(sb.size()), 4'd0);
    chk("final_pend", pending, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
